// File: rtl/isp_upscale_if.sv
// rtl/isp_upscale_if.sv - href/vsync YUV pixel stream bundle
interface isp_upscale_if #(
  parameter int BITS = 8
) ();
  logic            href;
  logic            vsync;
  logic [BITS-1:0] y;
  logic [BITS-1:0] u;
  logic [BITS-1:0] v;

  modport master (output href, output vsync, output y, output u, output v);
  modport slave  (input  href, input  vsync, input  y, input  u, input  v);
endinterface

// File: rtl/isp_upscale.sv
// rtl/isp_upscale.sv - integer-factor nearest-neighbour upscaler with ping-pong line buffer
module isp_upscale #(
  parameter int BITS  = 8,
  parameter int WIDTH = 1280,
  parameter int HGAP  = 4
) (
  input  logic               pclk,
  input  logic               rst,
  isp_upscale_if.slave       in_if,
  isp_upscale_if.master      out_if,
  input  logic [2:0]         up_w,
  input  logic [2:0]         up_h,
  output logic               err_overrun
);

  localparam int AW = $clog2(WIDTH);
  localparam int DW = 3 * BITS;

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_GAP} state_t;
  state_t state, state_nxt;

  logic          prev_href, prev_vsync, vsync_d1;
  logic          line_end, frame_start;
  logic [2:0]    fw, fh, px_rep, ln_rep;
  logic          wr_bank, rd_bank, pending, pend_bank;
  logic [11:0]   wr_addr, rd_addr;
  logic [11:0]   len [2];
  logic [15:0]   gap_cnt;
  logic [DW-1:0] mem [2][WIDTH];

  logic rd_issue, line_last, gap_last, rep_more, take_pend, reader_free, start_new;

  assign line_end    = prev_href & ~in_if.href;
  assign frame_start = prev_vsync & ~in_if.vsync;

  always_ff @(posedge pclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_new) state_nxt = S_LINE;
      S_LINE: if (line_last) state_nxt = S_GAP;
      S_GAP:  if (gap_last)  state_nxt = (rep_more || take_pend || start_new) ? S_LINE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A reader finishing its last replay counts as free, so a coincident line_end starts directly.
  always_comb begin
    rd_issue    = (state == S_LINE);
    line_last   = rd_issue && (px_rep >= fw - 3'd1) && (12'(rd_addr + 12'd1) >= len[rd_bank]);
    gap_last    = (state == S_GAP) && (gap_cnt == 16'(HGAP - 1));
    rep_more    = ln_rep < (fh - 3'd1);
    take_pend   = gap_last && !rep_more && pending;
    reader_free = (state == S_IDLE) || (gap_last && !rep_more && !pending);
    start_new   = line_end && reader_free;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_addr <= '0;
      px_rep  <= '0;
      ln_rep  <= '0;
      gap_cnt <= '0;
    end else begin
      if (start_new) begin
        rd_bank <= wr_bank;
        rd_addr <= '0;
        px_rep  <= '0;
        ln_rep  <= '0;
      end else if (take_pend) begin
        rd_bank <= pend_bank;
        rd_addr <= '0;
        px_rep  <= '0;
        ln_rep  <= '0;
      end else if (gap_last && rep_more) begin
        ln_rep  <= ln_rep + 3'd1;
        rd_addr <= '0;
        px_rep  <= '0;
      end else if (rd_issue) begin
        if (px_rep >= fw - 3'd1) begin
          px_rep  <= '0;
          rd_addr <= rd_addr + 12'd1;
        end else begin
          px_rep  <= px_rep + 3'd1;
        end
      end
      gap_cnt <= ((state == S_GAP) && !gap_last) ? gap_cnt + 16'd1 : '0;
    end
  end

  // frame_start is applied last so it overrides the write-side effects of a coincident line_end.
  always_ff @(posedge pclk) begin
    if (rst) begin
      prev_href   <= 1'b0;
      prev_vsync  <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      len[0]      <= '0;
      len[1]      <= '0;
      pending     <= 1'b0;
      pend_bank   <= 1'b0;
      fw          <= 3'd1;
      fh          <= 3'd1;
      err_overrun <= 1'b0;
    end else begin
      prev_href  <= in_if.href;
      prev_vsync <= in_if.vsync;
      if (in_if.href && (wr_addr < 12'(WIDTH))) wr_addr <= wr_addr + 12'd1;
      if (take_pend) pending <= 1'b0;
      if (line_end) begin
        len[wr_bank] <= wr_addr;
        wr_bank      <= ~wr_bank;
        wr_addr      <= '0;
        if (!reader_free) begin
          pending   <= 1'b1;
          pend_bank <= wr_bank;
          if (pending && !take_pend) err_overrun <= 1'b1;
        end
      end
      if (frame_start) begin
        fw      <= (up_w == 3'd0) ? 3'd1 : up_w;
        fh      <= (up_h == 3'd0) ? 3'd1 : up_h;
        wr_bank <= 1'b0;
        wr_addr <= '0;
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (in_if.href && (wr_addr < 12'(WIDTH)))
      mem[wr_bank][wr_addr[AW-1:0]] <= {in_if.y, in_if.u, in_if.v};
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_d1     <= 1'b0;
      out_if.vsync <= 1'b0;
      out_if.href  <= 1'b0;
      out_if.y     <= '0;
      out_if.u     <= '0;
      out_if.v     <= '0;
    end else begin
      vsync_d1     <= in_if.vsync;
      out_if.vsync <= vsync_d1;
      out_if.href  <= rd_issue;
      {out_if.y, out_if.u, out_if.v} <= rd_issue ? mem[rd_bank][rd_addr[AW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_isp_upscale.sv
// tb/tb_isp_upscale.sv - scoreboard bench for isp_upscale
module tb_isp_upscale;
  localparam int BITS  = 8;
  localparam int WIDTH = 8;
  localparam int HGAP  = 4;

  logic       pclk = 1'b0;
  logic       rst;
  logic [2:0] up_w, up_h;
  logic       err_overrun;

  isp_upscale_if #(.BITS(BITS)) in_if ();
  isp_upscale_if #(.BITS(BITS)) out_if ();

  isp_upscale #(.BITS(BITS), .WIDTH(WIDTH), .HGAP(HGAP)) dut (
    .pclk(pclk), .rst(rst), .in_if(in_if), .out_if(out_if),
    .up_w(up_w), .up_h(up_h), .err_overrun(err_overrun)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  logic [23:0] exp_q [$];
  int          exp_len [$];
  int          rise_q [$];
  int          n_cmp = 0, n_bad = 0;
  bit          chk_en = 1'b0;
  bit          in_run = 1'b0;
  int          run = 0;
  int          cur_fw = 1, cur_fh = 1;
  int          last_t = 0;
  logic [23:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pix(input int base, input int step, input int i);
    logic [7:0] y;
    y = 8'(base + i * step);
    return {y, y ^ 8'h5A, y + 8'd7};
  endfunction

  always @(negedge pclk) begin
    if (rst) begin
      in_run = 1'b0;
      run    = 0;
    end else if (out_if.href) begin
      if (!in_run) begin
        rise_q.push_back(cyc);
        in_run = 1'b1;
        run    = 0;
      end
      run++;
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pixel: unexpected output %h, none expected", {out_if.y, out_if.u, out_if.v});
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", 32'({out_if.y, out_if.u, out_if.v}), 32'(mon_e));
        end
      end
    end else if (in_run) begin
      in_run = 1'b0;
      if (chk_en) begin
        if (exp_len.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL line_len: unexpected line of %0d pixels", run);
        end else begin
          check("line_len", 32'(run), 32'(exp_len.pop_front()));
        end
        check("idle_data", 32'({out_if.y, out_if.u, out_if.v}), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic new_frame(input int w, input int h);
    @(negedge pclk);
    in_if.vsync = 1'b1;
    up_w = 3'(w);
    up_h = 3'(h);
    cur_fw = (w == 0) ? 1 : w;
    cur_fh = (h == 0) ? 1 : h;
    @(negedge pclk); check("vsync_rise_d1", 32'(out_if.vsync), 32'd0);
    @(negedge pclk); check("vsync_rise_d2", 32'(out_if.vsync), 32'd1);
    @(negedge pclk); in_if.vsync = 1'b0;
    @(negedge pclk); check("vsync_fall_d1", 32'(out_if.vsync), 32'd1);
    @(negedge pclk); check("vsync_fall_d2", 32'(out_if.vsync), 32'd0);
    tick(2);
  endtask

  task automatic send_line(input int n, input int base, input int step, input int blank, input bit expect_out);
    int lo;
    lo = (n > WIDTH) ? WIDTH : n;
    if (expect_out) begin
      for (int r = 0; r < cur_fh; r++) begin
        exp_len.push_back(lo * cur_fw);
        for (int i = 0; i < lo; i++)
          for (int k = 0; k < cur_fw; k++)
            exp_q.push_back(pix(base, step, i));
      end
    end
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      in_if.href = 1'b1;
      {in_if.y, in_if.u, in_if.v} = pix(base, step, i);
    end
    @(negedge pclk);
    in_if.href = 1'b0;
    {in_if.y, in_if.u, in_if.v} = '0;
    last_t = cyc;
    tick(blank - 1);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp_len.size() != 0 || out_if.href) && k < 3000) begin
      @(negedge pclk);
      k++;
    end
    if (k >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: drain timeout, %0d pixels outstanding", name, exp_q.size());
    end
    check(name, 32'(exp_q.size() + exp_len.size()), 32'd0);
  endtask

  initial begin
    int t0, k;
    rst = 1'b1;
    in_if.href = 1'b0; in_if.vsync = 1'b0;
    in_if.y = '0; in_if.u = '0; in_if.v = '0;
    up_w = 3'd1; up_h = 3'd1;
    tick(3);
    check("reset_href", 32'(out_if.href), 32'd0);
    check("reset_vsync", 32'(out_if.vsync), 32'd0);
    check("reset_data", 32'({out_if.y, out_if.u, out_if.v}), 32'd0);
    check("reset_err", 32'(err_overrun), 32'd0);
    rst = 1'b0;
    tick(2);
    chk_en = 1'b1;

    new_frame(1, 1);
    rise_q.delete();
    send_line(8, 0, 1, 20, 1'b1);
    t0 = last_t;
    wait_drain("bypass_drain");
    check("bypass_rises", 32'(rise_q.size()), 32'd1);
    if (rise_q.size() > 0) check("bypass_latency", 32'(rise_q[0]), 32'(t0 + 2));

    new_frame(2, 2);
    rise_q.delete();
    send_line(4, 10, 10, 36, 1'b1);
    wait_drain("x2_drain");
    check("x2_rises", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() > 1) check("x2_line_spacing", 32'(rise_q[1] - rise_q[0]), 32'd12);

    new_frame(0, 3);
    send_line(4, 50, 5, 30, 1'b1);
    send_line(4, 70, 5, 30, 1'b1);
    wait_drain("w0_h3_drain");

    new_frame(3, 1);
    send_line(5, 100, 3, 25, 1'b1);
    wait_drain("w3_drain");

    new_frame(2, 1);
    send_line(4, 20, 1, 20, 1'b1);
    up_w = 3'd3;
    send_line(4, 30, 1, 20, 1'b1);
    wait_drain("midframe_drain");

    new_frame(1, 1);
    send_line(10, 200, 1, 20, 1'b1);
    wait_drain("overlength_drain");

    new_frame(4, 4);
    chk_en = 1'b0;
    send_line(16, 0, 1, 2, 1'b0);
    send_line(16, 16, 1, 2, 1'b0);
    check("overrun_line2", 32'(err_overrun), 32'd0);
    send_line(16, 32, 1, 2, 1'b0);
    check("overrun_line3", 32'(err_overrun), 32'd1);
    send_line(16, 48, 1, 2, 1'b0);
    check("overrun_sticky", 32'(err_overrun), 32'd1);

    k = 0;
    while (!out_if.href && k < 200) begin
      @(negedge pclk);
      k++;
    end
    check("replay_active", 32'(out_if.href), 32'd1);
    rst = 1'b1;
    @(negedge pclk);
    check("midreset_href", 32'(out_if.href), 32'd0);
    check("midreset_data", 32'({out_if.y, out_if.u, out_if.v}), 32'd0);
    check("midreset_err", 32'(err_overrun), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_len.delete();
    tick(2);
    chk_en = 1'b1;

    new_frame(2, 2);
    send_line(4, 10, 10, 36, 1'b1);
    wait_drain("post_reset_drain");
    check("post_reset_err", 32'(err_overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/isp_upscale.md
# isp_upscale

Integer-factor nearest-neighbour upscaler for the YUV pixel stream. It captures each input line into a ping-pong line buffer, then replays it `up_h` times, with each pixel repeated `up_w` times. It is the expanding counterpart of the downscale stage and sits at the same point in the YUV back end, using the same href/vsync streaming protocol. Output lines lag input lines by one line; the integrator guarantees enough horizontal and vertical blanking.

## Interface
- `BITS`, default 8: width of each of Y, U and V.
- `WIDTH`, default 1280: maximum input line length; line buffer depth per bank.
- `HGAP`, default 4: cycles with `out_href` low between consecutive replayed output lines; minimum 1.
- `pclk`  in  1  the single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_href`  in  1  input line valid, high for each active pixel.
- `in_vsync`  in  1  input frame sync; high during vertical blanking.
- `in_y`, `in_u`, `in_v`  in  BITS each  input pixel components.
- `up_w`  in  3  horizontal factor; 0 is treated as 1; legal values 1..7.
- `up_h`  in  3  vertical factor; 0 is treated as 1.
- `out_href`  out  1  output pixel valid.
- `out_vsync`  out  1  `in_vsync` delayed by 2 cycles.
- `out_y`, `out_u`, `out_v`  out  BITS each  output pixel; forced to 0 when `out_href` is 0.
- `err_overrun`  out  1  sticky; set when the input outruns the replay.

## Operation
- Edge detection from registered `in_href` and `in_vsync`:
  - line_end = prev_href & ~in_href
  - frame_start = prev_vsync & ~in_vsync
- At frame_start:
  - latch the factors (`fw`, `fh`; 0 maps to 1).
  - `wr_bank` ← 0, `pending` ← 0, `wr_addr` ← 0.
  - The reader is not aborted; it finishes any replay in progress.
  - Factor changes mid-frame are ignored.
- Write side:
  - Each `in_href` cycle writes {y,u,v} to bank[`wr_bank`] at `wr_addr`, then `wr_addr`++.
  - Pixels beyond `WIDTH` are dropped (`wr_addr` saturates).
  - At line_end: `len[wr_bank]` ← `wr_addr`, `wr_bank` toggles, `wr_addr` ← 0, and the finished bank becomes ready.
- Ready-line handling at line_end:
  - Reader IDLE: it starts on the finished bank next cycle.
  - Reader busy and `pending`=0: `pending` ← 1, with the finished bank recorded.
  - Reader busy and `pending`=1: `err_overrun` ← 1; the pending bank is replaced by the newest one; data may be corrupt.
- Reader state machine:
  - IDLE → LINE on a ready line; clears `rd_addr`, `px_rep` and `ln_rep`.
  - LINE: each cycle issues a read of bank[`rd_bank`][`rd_addr`].
    - `px_rep` counts 0..fw-1; at fw-1 it wraps and `rd_addr`++.
    - After issuing `rd_addr`=len-1 with `px_rep`=fw-1, go to GAP.
  - GAP: counts HGAP cycles. Then:
    - if `ln_rep` < fh-1: `ln_rep`++ and return to LINE.
    - else if `pending`: take the pending bank, clear `pending`, go to LINE.
    - else go to IDLE.
- Output per input line of length L: fh lines of L·fw pixels, each followed by HGAP idle cycles.
- Counter widths:
  - `wr_addr`, `rd_addr`, `len`: 12 bits.
  - `px_rep`, `ln_rep`: 3 bits.
  - No wrap is possible given `WIDTH` ≤ 4095.
- Throughput constraint: the input line period must be ≥ fh·(L·fw + HGAP) cycles. Violation is reported only through `err_overrun`.

## Timing
- Line buffer read latency is 1 cycle. `out_href` and the data are registered together with the read.
- Latency: the first `in_href`-low cycle after a line is cycle T. When the reader is IDLE, the first `out_href`=1 is at cycle T+2.
- Within an output line, `out_href` stays continuously high for L·fw cycles.
- `out_vsync` = `in_vsync` delayed exactly 2 cycles. It is independent of the replay state.
- Reset values:
  - `out_href`=0, `out_vsync`=0, `out_y`/`out_u`/`out_v`=0, `err_overrun`=0.
  - FSM in IDLE, `pending`=0, `wr_bank`=0, `fw`=`fh`=1.
- Reset mid-replay: the next cycle shows `out_href`=0 and all state at reset values. Line buffer contents are don't-care.
- Simultaneous events:
  - line_end in the same cycle the reader leaves GAP for IDLE: the new line starts (no pending needed).
  - frame_start coinciding with line_end: the line_end is processed first, then the write state is cleared.

## Test plan
- **Bypass:** fw=fh=1, 8-pixel lines, Y=0..7 → identical 8-pixel output lines starting at T+2, `out_vsync` lagging 2 cycles.
- **2×2:** up_w=2, up_h=2, line Y=10,20,30,40 with a 40-cycle line period → two lines of Y=10,10,20,20,30,30,40,40, separated by 4 href-low cycles, per input line.
- **Factor 0 and odd factors:** up_w=0 (acts as 1) with up_h=3 → 3 copies per line. Also up_w=3 on a 5-pixel line → 15 pixels per output line.
- **Overrun:** up_w=4, up_h=4, 16-pixel lines back-to-back with 2-cycle blanking → `err_overrun` rises during the third line and stays high until `rst`.
- **Over-length:** `WIDTH`=8, 10-pixel input line → only the first 8 pixels are replayed.
- **Reset and frame control:** assert `rst` for 1 cycle mid-LINE → all outputs 0 next cycle, and the next frame upscales correctly. Change up_w mid-frame → no effect until the next frame_start.
